// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush sequencer.
// Stage indices, FSM encodings and the hold/flush mask helper.
package pipeline_stall_ctrl_pkg;

    localparam int NSTG = 5;

    // Bit positions inside the stall/flush vectors
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EXE = 3;
    localparam int STG_WB  = 4;

    // Store-type code for store-conditional
    localparam logic [2:0] STR_SC = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_EXC      = 2'd2
    } state_t;

    typedef struct packed {
        logic [NSTG-1:0] stall;
        logic [NSTG-1:0] flush;
    } hold_t;

    // Hold every register up to index k, bubble the one just after it
    function automatic hold_t hold_upto(input int k);
        hold_t h;
        h.stall = '0;
        h.flush = '0;
        for (int i = 0; i < NSTG; i++) begin
            if (i <= k)
                h.stall[i] = 1'b1;
            if (i == k + 1)
                h.flush[i] = 1'b1;
        end
        return h;
    endfunction

    // Exception squashes IF/ID..EXE/MEM; MEM/WB belongs to MEM
    localparam logic [NSTG-1:0] FLUSH_EXC = 5'b01111;

endpackage

// File: rtl/stall_priority_enc.sv
// Maps stall sources onto stall/flush vectors.
// The deepest requesting stage wins; purely combinational.
module stall_priority_enc
    import pipeline_stall_ctrl_pkg::*;
(
    input  logic            mem_miss,
    input  logic            div_busy,
    input  logic            id_hazard,
    input  logic            if_miss,
    output logic [NSTG-1:0] stall,
    output logic [NSTG-1:0] flush
);

    hold_t h;

    // Pick the deepest source and expand it into hold/bubble masks
    always_comb begin
        h = '0;
        priority case (1'b1)
            mem_miss:  h = hold_upto(STG_EXE);
            div_busy:  h = hold_upto(STG_ID);
            id_hazard: h = hold_upto(STG_IF);
            if_miss:   h = hold_upto(STG_PC);
            default:   h = '0;
        endcase
        stall = h.stall;
        flush = h.flush;
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Owns the divider handshake, exception redirect and stall counter.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stcl_lw,
    input  logic              stcl_jmp,
    input  logic              if_miss,
    input  logic              mem_miss,
    input  logic              exe_div_req,
    input  logic              div_done,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_target,
    output logic              div_start,
    output logic              div_abort,
    output logic [NSTG-1:0]   stall,
    output logic [NSTG-1:0]   flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  stall_cycles
);

    state_t state_q;
    state_t state_d;

    logic            div_busy;
    logic            in_run;
    logic            in_div;
    logic            in_exc;
    logic [NSTG-1:0] src_stall;
    logic [NSTG-1:0] src_flush;

    assign in_run = (state_q == ST_RUN);
    assign in_div = (state_q == ST_DIV_WAIT);
    assign in_exc = (state_q == ST_EXC);

    // Divider occupies EXE until its result arrives
    assign div_busy = (in_div && !div_done) ||
                      (in_run && exe_div_req);

    stall_priority_enc u_enc (
        .mem_miss  (mem_miss),
        .div_busy  (div_busy),
        .id_hazard (stcl_lw | stcl_jmp),
        .if_miss   (if_miss),
        .stall     (src_stall),
        .flush     (src_flush)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // Next-state: exceptions preempt everything, divider waits out mem_miss
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (exc_valid)
                    state_d = ST_EXC;
                else if (exe_div_req && !mem_miss)
                    state_d = ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
                if (exc_valid)
                    state_d = ST_EXC;
                else if (div_done && !mem_miss)
                    state_d = ST_RUN;
            end
            ST_EXC: begin
                if (exc_valid)
                    state_d = ST_EXC;
                else if (!if_miss)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Outputs: exception override, then redirect hold, then stall sources
    always_comb begin
        stall          = '0;
        flush          = '0;
        div_start      = 1'b0;
        div_abort      = 1'b0;
        redirect_valid = 1'b0;
        if (!rst) begin
            if (exc_valid) begin
                flush = FLUSH_EXC;
            end else if (in_exc) begin
                flush[STG_IF]  = 1'b1;
                stall[STG_PC]  = if_miss;
            end else begin
                stall = src_stall;
                flush = src_flush;
            end
            div_start = in_run && exe_div_req &&
                        !mem_miss && !exc_valid;
            div_abort      = in_div && exc_valid;
            redirect_valid = in_exc;
        end
    end

    // Capture the redirect target on every committed exception
    always_ff @(posedge clk) begin
        if (rst)
            redirect_pc <= '0;
        else if (exc_valid)
            redirect_pc <= exc_target;
    end

    // Saturating count of cycles the PC was held
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall[STG_PC] && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl.
// Directed vectors push expectations; a monitor pops and compares.
module tb_pipeline_stall_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    localparam logic [7:0] RST  = 8'h80;
    localparam logic [7:0] LW   = 8'h40;
    localparam logic [7:0] JMP  = 8'h20;
    localparam logic [7:0] IFM  = 8'h10;
    localparam logic [7:0] MEMM = 8'h08;
    localparam logic [7:0] DREQ = 8'h04;
    localparam logic [7:0] DD   = 8'h02;
    localparam logic [7:0] EXC  = 8'h01;

    typedef struct packed {
        logic [4:0]        st;
        logic [4:0]        fl;
        logic              ds;
        logic              da;
        logic              rv;
        logic [ADDR_W-1:0] pc;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              stcl_lw;
    logic              stcl_jmp;
    logic              if_miss;
    logic              mem_miss;
    logic              exe_div_req;
    logic              div_done;
    logic              exc_valid;
    logic [ADDR_W-1:0] exc_target;
    logic              div_start;
    logic              div_abort;
    logic [4:0]        stall;
    logic [4:0]        flush;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  stall_cycles;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;
    logic [CNT_W-1:0] mcnt = '0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stcl_lw        (stcl_lw),
        .stcl_jmp       (stcl_jmp),
        .if_miss        (if_miss),
        .mem_miss       (mem_miss),
        .exe_div_req    (exe_div_req),
        .div_done       (div_done),
        .exc_valid      (exc_valid),
        .exc_target     (exc_target),
        .div_start      (div_start),
        .div_abort      (div_abort),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_cycles   (stall_cycles)
    );

    task automatic set_in(input logic [7:0] in,
                          input logic [ADDR_W-1:0] tgt);
        {rst, stcl_lw, stcl_jmp, if_miss,
         mem_miss, exe_div_req, div_done, exc_valid} = in;
        exc_target = tgt;
    endtask

    // Apply one cycle of inputs and queue the hand-computed response
    task automatic vec(input logic [7:0] in,
                       input logic [ADDR_W-1:0] tgt,
                       input logic [4:0] es,
                       input logic [4:0] ef,
                       input logic [2:0] ctl,
                       input logic [ADDR_W-1:0] epc);
        exp_t e;
        @(posedge clk);
        #1;
        set_in(in, tgt);
        e.st  = es;
        e.fl  = ef;
        {e.ds, e.da, e.rv} = ctl;
        e.pc  = epc;
        e.cnt = mcnt;
        q.push_back(e);
        if (in[7])
            mcnt = '0;
        else if (es[0] && mcnt != '1)
            mcnt = mcnt + 1'b1;
    endtask

    // Monitor: compare every queued expectation mid-cycle
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                a = {stall, flush, div_start, div_abort,
                     redirect_valid, redirect_pc, stall_cycles};
                vec_id++;
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL vec%0d got st=%b fl=%b ds=%b da=%b rv=%b pc=%h cnt=%0d want st=%b fl=%b ds=%b da=%b rv=%b pc=%h cnt=%0d",
                             vec_id, a.st, a.fl, a.ds, a.da, a.rv, a.pc, a.cnt,
                             e.st, e.fl, e.ds, e.da, e.rv, e.pc, e.cnt);
                end
            end
        end
    end

    initial begin
        set_in(RST, '0);
        repeat (2) @(posedge clk);

        // reset state
        vec(8'h00, 0, 5'b00000, 5'b00000, 3'b000, 0);
        // load-use hazard, then release
        vec(LW,    0, 5'b00011, 5'b00100, 3'b000, 0);
        vec(8'h00, 0, 5'b00000, 5'b00000, 3'b000, 0);
        // divide: start pulse, 5 busy cycles, done releases
        vec(DREQ,  0, 5'b00111, 5'b01000, 3'b100, 0);
        repeat (4)
            vec(DREQ, 0, 5'b00111, 5'b01000, 3'b000, 0);
        vec(DREQ|DD, 0, 5'b00000, 5'b00000, 3'b000, 0);
        vec(8'h00, 0, 5'b00000, 5'b00000, 3'b000, 0);
        // exception during divide wait aborts it
        vec(DREQ,  0, 5'b00111, 5'b01000, 3'b100, 0);
        vec(DREQ|EXC, 32'hBFC00380, 5'b00000, 5'b01111, 3'b010, 0);
        // redirect held while I-cache misses
        repeat (3)
            vec(IFM, 0, 5'b00001, 5'b00010, 3'b001, 32'hBFC00380);
        vec(8'h00, 0, 5'b00000, 5'b00010, 3'b001, 32'hBFC00380);
        vec(8'h00, 0, 5'b00000, 5'b00000, 3'b000, 32'hBFC00380);
        // mem_miss outranks hazards and the divider
        vec(MEMM|JMP,  0, 5'b01111, 5'b10000, 3'b000, 32'hBFC00380);
        vec(MEMM|DREQ, 0, 5'b01111, 5'b10000, 3'b000, 32'hBFC00380);
        vec(DREQ,      0, 5'b00111, 5'b01000, 3'b100, 32'hBFC00380);
        // done under mem_miss holds, released once miss clears
        vec(DREQ|DD|MEMM, 0, 5'b01111, 5'b10000, 3'b000, 32'hBFC00380);
        vec(DREQ|DD,      0, 5'b00000, 5'b00000, 3'b000, 32'hBFC00380);
        // back in RUN: new divide starts, counter saturates at 15
        vec(DREQ, 0, 5'b00111, 5'b01000, 3'b100, 32'hBFC00380);
        vec(DREQ, 0, 5'b00111, 5'b01000, 3'b000, 32'hBFC00380);
        vec(DREQ, 0, 5'b00111, 5'b01000, 3'b000, 32'hBFC00380);
        // reset mid-divide: no abort, no latch, then all clear
        vec(RST|DREQ|EXC, 32'h12345678, 5'b00000, 5'b00000, 3'b000, 32'hBFC00380);
        vec(8'h00, 0, 5'b00000, 5'b00000, 3'b000, 0);
        // exception in RUN, re-raised while in EXC re-latches target
        vec(EXC, 32'h80000180, 5'b00000, 5'b01111, 3'b000, 0);
        vec(EXC, 32'h80000200, 5'b00000, 5'b01111, 3'b001, 32'h80000180);
        vec(8'h00, 0, 5'b00000, 5'b00010, 3'b001, 32'h80000200);
        vec(8'h00, 0, 5'b00000, 5'b00000, 3'b000, 32'h80000200);
        // hazard beats I-cache miss; I-cache miss alone
        vec(IFM|JMP, 0, 5'b00011, 5'b00100, 3'b000, 32'h80000200);
        vec(IFM,     0, 5'b00001, 5'b00010, 3'b000, 32'h80000200);

        @(posedge clk);
        #1;
        set_in(8'h00, 0);
        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain left=%0d want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
